tree_accum_seq: RTL

Sequencer that reduces a long vector, stored as a bank of LANES-wide chunks, through a single shared `adder_tree` instance. It issues chunk read addresses to a synchronous-read buffer, feeds each returned chunk through the tree, and accumulates the partial sums. It presents the total on a valid/ready output. It sits between the spike/weight buffers and the neuron update logic, where one adder tree serves a whole layer row instead of one tree per row.

---
 rtl/snn_ff_pkg.sv | 13 +
 rtl/tree_accum_seq_adder_tree.sv | 24 ++
 rtl/tree_accum_seq.sv | 76 +++++++
 3 files changed

// File: rtl/snn_ff_pkg.sv
// snn_ff_pkg: shared FSM state type and width helpers for the SNN feed-forward datapath.
package snn_ff_pkg;
  typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_e;
  function automatic int aw_f(input int max_chunks);
    return (max_chunks > 1) ? $clog2(max_chunks) : 1;
  endfunction
  function automatic int cw_f(input int max_chunks);
    return $clog2(max_chunks + 1);
  endfunction
  function automatic int sw_f(input int width, input int lanes, input int max_chunks);
    return width + $clog2(lanes) + $clog2(max_chunks);
  endfunction
endpackage

// File: rtl/tree_accum_seq_adder_tree.sv
// adder_tree: combinational pairwise reduction of N unsigned lanes.
module adder_tree #(
  parameter int N     = 4,
  parameter int WIDTH = 16
) (
  input  logic [N*WIDTH-1:0]         data_in,
  output logic [WIDTH+$clog2(N)-1:0] sum_out
);
  localparam int OW = WIDTH + $clog2(N);
  localparam int P  = 1 << $clog2(N);
  // heap layout: node 0 is the root, children of i are 2i+1 and 2i+2, leaves padded to a power of two
  logic [OW-1:0] node [2*P-1];
  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < N) begin : g_in
      assign node[P-1+i] = OW'(data_in[WIDTH*i +: WIDTH]);
    end else begin : g_pad
      assign node[P-1+i] = '0;
    end
  end
  for (genvar i = 0; i < P-1; i++) begin : g_node
    assign node[i] = node[2*i+1] + node[2*i+2];
  end
  assign sum_out = node[0];
endmodule

// File: rtl/tree_accum_seq.sv
// tree_accum_seq: streams buffer chunks through one shared adder tree and accumulates the total.
module tree_accum_seq
  import snn_ff_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int WIDTH      = 16,
  parameter int MAX_CHUNKS = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [cw_f(MAX_CHUNKS)-1:0]             num_chunks,
  input  logic                                    abort,
  output logic                                    busy,
  output logic                                    rd_en,
  output logic [aw_f(MAX_CHUNKS)-1:0]             rd_addr,
  input  logic [LANES*WIDTH-1:0]                  rd_data,
  output logic [sw_f(WIDTH, LANES, MAX_CHUNKS)-1:0] sum,
  output logic                                    sum_valid,
  input  logic                                    sum_ready
);
  localparam int AW = aw_f(MAX_CHUNKS);
  localparam int CW = cw_f(MAX_CHUNKS);
  localparam int SW = sw_f(WIDTH, LANES, MAX_CHUNKS);
  localparam int TW = WIDTH + $clog2(LANES);
  state_e        state_q, state_d;
  logic [CW-1:0] n_q, n_d, cnt_q, cnt_d, n_clamp;
  logic [SW-1:0] acc_q, acc_d;
  logic          data_vld_q, data_vld_d;
  logic [TW-1:0] tree_out;
  adder_tree #(.N(LANES), .WIDTH(WIDTH)) u_tree (.data_in(rd_data), .sum_out(tree_out));
  assign n_clamp   = (num_chunks > CW'(MAX_CHUNKS)) ? CW'(MAX_CHUNKS) : num_chunks;
  assign busy      = state_q != IDLE;
  assign rd_en     = state_q == RUN;
  assign rd_addr   = cnt_q[AW-1:0];
  assign sum_valid = state_q == DONE;
  assign sum       = sum_valid ? acc_q : '0;
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    acc_d      = (data_vld_q && !abort) ? acc_q + SW'(tree_out) : acc_q;
    data_vld_d = !abort && rd_en;
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        n_d     = n_clamp;
        cnt_d   = '0;
        acc_d   = '0;
        // an empty reduction still passes through LAST so its latency matches n+1 edges
        state_d = (n_clamp == '0) ? LAST : RUN;
      end
      RUN: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == n_q - CW'(1)) ? LAST : RUN;
      end
      LAST: state_d = DONE;
      DONE: state_d = sum_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      data_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      data_vld_q <= data_vld_d;
    end
  end
endmodule
